// File: rtl/sdram_line_port.sv
// rtl/sdram_line_port.sv - cache line-fill burst reader with posted-write FIFO toward SDRAM
module sdram_line_port #(
    parameter int WBUF_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] cpu_addr,
    input  logic        fill_req,
    output logic        fill,
    output logic [15:0] fill_data,
    input  logic        wr_req,
    input  logic [31:0] wr_addr,
    input  logic [15:0] wr_data,
    input  logic [1:0]  wr_be,
    output logic        wr_full,
    output logic        wr_overflow,
    output logic        busy,
    output logic        mem_req,
    output logic        mem_we,
    output logic [24:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic [1:0]  mem_be,
    input  logic        mem_ack,
    input  logic        mem_rvalid,
    input  logic [15:0] mem_rdata
);

    localparam int AW = (WBUF_DEPTH > 1) ? $clog2(WBUF_DEPTH) : 1;
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(WBUF_DEPTH);

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_WR_CMD     = 3'd1;
    localparam logic [2:0] S_RD_CMD     = 3'd2;
    localparam logic [2:0] S_RD_COLLECT = 3'd3;
    localparam logic [2:0] S_FILL_OUT   = 3'd4;

    logic [2:0]    state;

    logic [24:0]   fifo_addr [WBUF_DEPTH];
    logic [15:0]   fifo_data [WBUF_DEPTH];
    logic [1:0]    fifo_be   [WBUF_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;

    logic [15:0]   line_buf [4];
    logic [1:0]    word_cnt;
    logic [1:0]    out_idx;

    logic          push;
    logic          pop;

    // Only byte-address bits 25:1 reach SDRAM; the rest are deliberately ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{cpu_addr[31:26], cpu_addr[0], wr_addr[31:26], wr_addr[0]};

    assign wr_full = (count == FULL_COUNT);
    assign push    = wr_req && !wr_full;
    assign pop     = (state == S_WR_CMD) && mem_ack;
    assign busy    = (state != S_IDLE) || (count != '0);

    // Posted-write storage; contents need no reset since count gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr] <= wr_addr[25:1];
            fifo_data[wr_ptr] <= wr_data;
            fifo_be[wr_ptr]   <= wr_be;
        end
    end

    // FIFO pointers, occupancy and sticky overflow flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            wr_overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (!push && pop) begin
                count <= count - 1'b1;
            end
            if (wr_req && wr_full) begin
                wr_overflow <= 1'b1;
            end
        end
    end

    // Line buffer filled in arrival order, so slot 0 holds the critical word.
    always_ff @(posedge clk) begin
        if (state == S_RD_COLLECT && mem_rvalid) begin
            line_buf[word_cnt] <= mem_rdata;
        end
    end

    // Command sequencer: drains posted writes first, then bursts the line and replays it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= '0;
            fill      <= 1'b0;
            fill_data <= '0;
            word_cnt  <= '0;
            out_idx   <= '0;
        end else begin
            fill <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (count != '0) begin
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b1;
                        mem_addr  <= fifo_addr[rd_ptr];
                        mem_wdata <= fifo_data[rd_ptr];
                        mem_be    <= fifo_be[rd_ptr];
                        state     <= S_WR_CMD;
                    end else if (fill_req) begin
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= cpu_addr[25:1];
                        mem_be   <= 2'b11;
                        state    <= S_RD_CMD;
                    end
                end
                S_WR_CMD: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        state   <= S_IDLE;
                    end
                end
                S_RD_CMD: begin
                    if (mem_ack) begin
                        mem_req  <= 1'b0;
                        word_cnt <= '0;
                        state    <= S_RD_COLLECT;
                    end
                end
                S_RD_COLLECT: begin
                    if (mem_rvalid) begin
                        word_cnt <= word_cnt + 1'b1;
                        if (word_cnt == 2'd3) begin
                            // Slot 0 goes out with the strobe; the rest follow from FILL_OUT.
                            fill      <= 1'b1;
                            fill_data <= line_buf[0];
                            out_idx   <= 2'd1;
                            state     <= S_FILL_OUT;
                        end
                    end
                end
                S_FILL_OUT: begin
                    fill_data <= line_buf[out_idx];
                    out_idx   <= out_idx + 1'b1;
                    if (out_idx == 2'd3) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/sdram_line_port.md
# sdram_line_port

Memory-side stage directly downstream of the two-way read cache. Turns the cache's line-fill request into a 4-word burst read on the SDRAM controller port and replays the burst to the cache on four consecutive cycles. Also queues write-through CPU writes in a small posted-write FIFO and issues them to SDRAM ahead of any fill, preserving read-after-write order.

## Interface
- WBUF_DEPTH, 4, posted-write FIFO entries; power of two, 2..16
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high; clears all state
- cpu_addr  in  32  byte address of the missing word; bits 25:1 used; stable from fill_req rise until fill
- fill_req  in  1  line-fill request (cache sdram_req); level, held until the fill cycle
- fill  out  1  one-cycle strobe: first fill word on fill_data (cache sdram_fill)
- fill_data  out  16  fill word; valid on the fill cycle and the 3 following cycles
- wr_req  in  1  one-cycle pulse per CPU write
- wr_addr  in  32  write byte address; bits 25:1 used
- wr_data  in  16  write data
- wr_be  in  2  byte enables {upper, lower}, active-high
- wr_full  out  1  FIFO holds WBUF_DEPTH entries
- wr_overflow  out  1  sticky: a wr_req arrived while wr_full; cleared only by reset
- busy  out  1  state != IDLE or FIFO non-empty
- mem_req  out  1  command request to SDRAM controller
- mem_we  out  1  1 = single-word write, 0 = 4-word burst read
- mem_addr  out  25  word address (byte address bits 25:1)
- mem_wdata  out  16  write data
- mem_be  out  2  write byte enables; 2'b11 on reads
- mem_ack  in  1  one-cycle command acceptance
- mem_rvalid  in  1  read word valid; 4 per burst, gaps allowed, wrap order from mem_addr[1:0]
- mem_rdata  in  16  read word

## Operation
- States: IDLE, WR_CMD, RD_CMD, RD_COLLECT, FILL_OUT.
- FIFO push: wr_req with wr_full=0 stores {addr[25:1], data, be}. wr_req with wr_full=1 is dropped and sets wr_overflow. Push and pop in the same cycle are both honoured.
- IDLE, FIFO non-empty (priority): load mem_* from FIFO head with mem_we=1 and mem_req=1, go to WR_CMD.
- IDLE, FIFO empty, fill_req=1: latch cpu_addr[25:1], drive mem_addr with it, mem_we=0, mem_be=2'b11, mem_req=1, go to RD_CMD.
- WR_CMD: on mem_ack, pop the head, drop mem_req, go to IDLE.
- RD_CMD: on mem_ack, drop mem_req, clear the word counter, go to RD_COLLECT.
- RD_COLLECT: each mem_rvalid writes mem_rdata into line buffer slot [counter] and increments a 2-bit counter. On the 4th word, go to FILL_OUT.
- FILL_OUT: replay slots 0..3 on consecutive cycles, with fill=1 on slot 0 only. The line buffer is in arrival order, so slot 0 is the critical word. Return to IDLE after slot 3.
- mem_rvalid outside RD_COLLECT is ignored.
- wr_req continues to be accepted in every state, including during a fill.
- FIFO count is (log2(WBUF_DEPTH)+1) bits; pointers wrap modulo WBUF_DEPTH.
- wr_full = (count == WBUF_DEPTH), combinational from the registered count.

## Timing
- Reset values: fill, fill_data, mem_req, mem_we, mem_addr, mem_wdata, mem_be, wr_overflow, busy all 0; FIFO empty, so wr_full=0; state IDLE.
- mem_req and mem_addr/we/wdata/be are registered and held stable from assertion through the mem_ack cycle inclusive. mem_req is 0 the cycle after mem_ack.
- Write latency: wr_req at cycle N into an empty FIFO in IDLE gives mem_req=1 at N+2.
- Fill latency: fill_req sampled in IDLE at cycle N (FIFO empty) gives mem_req=1 at N+1.
- 4th mem_rvalid at cycle M gives fill=1 at M+1, and slots 1..3 at M+2..M+4. fill_data holds slot 3 afterwards.
- fill_req is not re-sampled until IDLE following FILL_OUT. The cache drops fill_req the cycle after fill, so there is no spurious second fill.
- A write queued while a fill is in flight is issued after FILL_OUT completes.
- Reset mid-operation:
  - any state returns to IDLE and queued writes are lost;
  - rvalids still arriving are ignored;
  - an asserted mem_req falls the cycle after reset.

## Test plan
- Reset, then fill_req with cpu_addr=0x0000_1234 and FIFO empty. Expect mem_req next cycle, mem_addr=0x091A, mem_we=0. After ack, rdata A,B,C,D on consecutive cycles: fill=1 with A, then B,C,D on the next 3 cycles.
- Same fill with rvalid gaps (A, 2 idle, B, 5 idle, C, D). Expect identical output: fill 1 cycle after D, and 4 contiguous words.
- Two wr_req (addr 0x10/data 0xBEEF/be 11, addr 0x13/data 0x00AA/be 01), then fill_req. Expect 2 write commands in order (mem_addr 0x008, 0x009) before the read command.
- Five wr_req back-to-back with mem_ack held low (WBUF_DEPTH=4). Expect wr_full after the 4th, the 5th dropped, wr_overflow=1, and exactly 4 writes issued once acks resume.
- Assert reset during RD_COLLECT after 2 words; send the remaining 2 rvalids. Expect no fill, mem_req=0, busy=0, and a clean fill on the next request.
